// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Geometry defaults, counter width and the modular offset helper shared by
//   the raster timing generator and its sync window comparators.
package video_timing_pkg;

  localparam int CNT_W  = 9;   // H/V counters and HPOS/VPOS width
  localparam int OFFS_W = 4;   // signed sync offset width

  localparam int DEF_HTOTAL   = 320;
  localparam int DEF_VTOTAL   = 260;
  localparam int DEF_HACT_BEG = 29;
  localparam int DEF_HACT_END = 285;
  localparam int DEF_HNARROW  = 8;
  localparam int DEF_VACT     = 224;
  localparam int DEF_HS_POS   = 296;
  localparam int DEF_HS_LEN   = 24;
  localparam int DEF_VS_POS   = 234;
  localparam int DEF_VS_LEN   = 4;
  localparam int DEF_HBIAS    = 16;
  localparam int DEF_CW       = 12;

  // (base + offs) folded back into [0, total). A single correction step is
  // enough because |offs| and any added length stay below total.
  function automatic logic [CNT_W-1:0] mod_add(input int base, input int offs,
                                               input int total);
    int sum;
    sum = base + offs;
    if (sum < 0)
      sum = sum + total;
    else if (sum >= total)
      sum = sum - total;
    return CNT_W'(sum);
  endfunction

endpackage

// File: rtl/video_timing_gen_sync_window.sv
// sync_window
//   Combinational test of whether a raster counter lies in the sync window
//   [B, E), where B = POS + offs and E = B + LEN, both modulo TOTAL.
//   Ports:
//     cnt       in  CNT_W   current H or V counter
//     offs      in  OFFS_W  signed offset applied to POS
//     in_window out 1       active-high window hit
module sync_window
  import video_timing_pkg::*;
#(
  parameter int TOTAL = DEF_HTOTAL,
  parameter int POS   = DEF_HS_POS,
  parameter int LEN   = DEF_HS_LEN
) (
  input  logic [CNT_W-1:0]         cnt,
  input  logic signed [OFFS_W-1:0] offs,
  output logic                     in_window
);

  logic [CNT_W-1:0] w_beg;
  logic [CNT_W-1:0] w_end;

  always_comb begin
    w_beg = mod_add(POS, int'(offs), TOTAL);
    w_end = mod_add(int'(w_beg), LEN, TOTAL);
    if (LEN == 0)
      in_window = 1'b0;
    else if (w_beg < w_end)
      in_window = (cnt >= w_beg) && (cnt < w_end);
    else
      // window straddles the counter wrap
      in_window = (cnt >= w_beg) || (cnt < w_end);
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator. Free-running H/V counters advance
//   on PCLK_EN; blanking, syncs, gated colour and line/frame strobes are
//   registered from the pre-increment counter values. Sync offsets are
//   latched once per frame so mid-frame changes never tear the raster.
//   Ports:
//     CLK, RESET         clock, synchronous active-high reset
//     PCLK_EN            pixel-clock enable
//     NARROW             selects the narrow colour-gating window
//     HOFFS, VOFFS       signed sync offsets (-8..+7)
//     iRGB / oRGB        colour in / registered blanked colour out
//     HPOS, VPOS         renderer coordinates (combinational from counters)
//     HBLK, VBLK         registered wide H blank, V blank
//     HSYN, VSYN         registered active-low syncs
//     LSTART, FSTART     one-enable line / frame start strobes
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int HTOTAL   = DEF_HTOTAL,
  parameter int VTOTAL   = DEF_VTOTAL,
  parameter int HACT_BEG = DEF_HACT_BEG,
  parameter int HACT_END = DEF_HACT_END,
  parameter int HNARROW  = DEF_HNARROW,
  parameter int VACT     = DEF_VACT,
  parameter int HS_POS   = DEF_HS_POS,
  parameter int HS_LEN   = DEF_HS_LEN,
  parameter int VS_POS   = DEF_VS_POS,
  parameter int VS_LEN   = DEF_VS_LEN,
  parameter int HBIAS    = DEF_HBIAS,
  parameter int CW       = DEF_CW
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     PCLK_EN,
  input  logic                     NARROW,
  input  logic signed [OFFS_W-1:0] HOFFS,
  input  logic signed [OFFS_W-1:0] VOFFS,
  input  logic [CW-1:0]            iRGB,
  output logic [CNT_W-1:0]         HPOS,
  output logic [CNT_W-1:0]         VPOS,
  output logic [CW-1:0]            oRGB,
  output logic                     HBLK,
  output logic                     VBLK,
  output logic                     HSYN,
  output logic                     VSYN,
  output logic                     LSTART,
  output logic                     FSTART
);

  localparam logic [CNT_W-1:0] L_HLAST  = CNT_W'(HTOTAL - 1);
  localparam logic [CNT_W-1:0] L_VLAST  = CNT_W'(VTOTAL - 1);
  localparam logic [CNT_W-1:0] L_VTOTAL = CNT_W'(VTOTAL);
  localparam logic [CNT_W-1:0] L_HBEG   = CNT_W'(HACT_BEG);
  localparam logic [CNT_W-1:0] L_HEND   = CNT_W'(HACT_END);
  localparam logic [CNT_W-1:0] L_NBEG   = CNT_W'(HACT_BEG + HNARROW);
  localparam logic [CNT_W-1:0] L_NEND   = CNT_W'(HACT_END - HNARROW);
  localparam logic [CNT_W-1:0] L_VACT   = CNT_W'(VACT);
  localparam logic [CNT_W-1:0] L_HBIAS  = CNT_W'(HBIAS);

  logic [CNT_W-1:0]         r_hcnt, r_vcnt;
  logic signed [OFFS_W-1:0] r_hoffs, r_voffs;
  logic [CW-1:0]            r_rgb;
  logic                     r_hblk, r_vblk, r_hsyn, r_vsyn, r_lstart, r_fstart;

  logic w_hlast, w_vlast;
  logic w_hblk_wide, w_hblk_narrow, w_vblk, w_gate;
  logic w_hs_win, w_vs_win;

  assign w_hlast = (r_hcnt == L_HLAST);
  assign w_vlast = (r_vcnt == L_VLAST);

  assign w_hblk_wide   = (r_hcnt < L_HBEG) || (r_hcnt >= L_HEND);
  assign w_hblk_narrow = (r_hcnt < L_NBEG) || (r_hcnt >= L_NEND);
  assign w_vblk        = (r_vcnt >= L_VACT);
  // colour gating follows NARROW; the HBLK port always reports the wide window
  assign w_gate        = (NARROW ? w_hblk_narrow : w_hblk_wide) || w_vblk;

  sync_window #(.TOTAL(HTOTAL), .POS(HS_POS), .LEN(HS_LEN)) u_hs_win (
    .cnt       (r_hcnt),
    .offs      (r_hoffs),
    .in_window (w_hs_win)
  );

  sync_window #(.TOTAL(VTOTAL), .POS(VS_POS), .LEN(VS_LEN)) u_vs_win (
    .cnt       (r_vcnt),
    .offs      (r_voffs),
    .in_window (w_vs_win)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_hoffs  <= '0;
      r_voffs  <= '0;
      r_rgb    <= '0;
      r_hblk   <= 1'b1;
      r_vblk   <= 1'b1;
      r_hsyn   <= 1'b1;
      r_vsyn   <= 1'b1;
      r_lstart <= 1'b0;
      r_fstart <= 1'b0;
    end else if (PCLK_EN) begin
      if (w_hlast) begin
        r_hcnt <= '0;
        if (w_vlast) begin
          r_vcnt  <= '0;
          // last pixel of the frame: new offsets apply from the next line 0
          r_hoffs <= HOFFS;
          r_voffs <= VOFFS;
        end else begin
          r_vcnt <= r_vcnt + 1'b1;
        end
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end

      r_rgb    <= w_gate ? '0 : iRGB;
      r_hblk   <= w_hblk_wide;
      r_vblk   <= w_vblk;
      r_hsyn   <= ~w_hs_win;
      r_vsyn   <= ~w_vs_win;
      r_lstart <= (r_hcnt == '0);
      r_fstart <= (r_hcnt == '0) && (r_vcnt == '0);
    end
  end

  // Lines past 255 map to negative VPOS so the renderers see the bottom
  // border as lines just above line 0.
  assign HPOS   = r_hcnt - L_HBIAS;
  assign VPOS   = r_vcnt[CNT_W-1] ? (r_vcnt - L_VTOTAL) : r_vcnt;
  assign oRGB   = r_rgb;
  assign HBLK   = r_hblk;
  assign VBLK   = r_vblk;
  assign HSYN   = r_hsyn;
  assign VSYN   = r_vsyn;
  assign LSTART = r_lstart;
  assign FSTART = r_fstart;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Two instances share all inputs:
//   u_dut  : default horizontal geometry, 16-line frame (5120 enables/frame)
//            so several frames of H-sync / offset-latch behaviour fit quickly.
//   u_dutv : 8-pixel lines with default vertical geometry (2080 enables/frame)
//            for the VSYN line numbers and the VPOS wrap above line 255.
// n counts enables since reset release; both rasters are functions of n.
module tb_video_timing_gen;

  localparam int CW = 12;
  localparam int H1 = 320, V1 = 16, F1 = H1 * V1;
  localparam int H2 = 8,   V2 = 260;

  logic          CLK = 1'b0;
  logic          RESET, PCLK_EN, NARROW;
  logic [3:0]    HOFFS, VOFFS;
  logic [CW-1:0] iRGB;

  logic [8:0]    HPOS, VPOS, HPOS2, VPOS2;
  logic [CW-1:0] oRGB, oRGB2;
  logic          HBLK, VBLK, HSYN, VSYN, LSTART, FSTART;
  logic          HBLK2, VBLK2, HSYN2, VSYN2, LSTART2, FSTART2;

  int n;
  int tests;
  int fails;

  always #5 CLK = ~CLK;

  video_timing_gen #(.VTOTAL(V1), .VACT(10), .VS_POS(12), .VS_LEN(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .NARROW(NARROW),
    .HOFFS(HOFFS), .VOFFS(VOFFS), .iRGB(iRGB),
    .HPOS(HPOS), .VPOS(VPOS), .oRGB(oRGB), .HBLK(HBLK), .VBLK(VBLK),
    .HSYN(HSYN), .VSYN(VSYN), .LSTART(LSTART), .FSTART(FSTART)
  );

  video_timing_gen #(.HTOTAL(H2), .HACT_BEG(1), .HACT_END(7), .HNARROW(1),
                     .HS_POS(4), .HS_LEN(2), .HBIAS(0)) u_dutv (
    .CLK(CLK), .RESET(RESET), .PCLK_EN(PCLK_EN), .NARROW(NARROW),
    .HOFFS(HOFFS), .VOFFS(VOFFS), .iRGB(iRGB),
    .HPOS(HPOS2), .VPOS(VPOS2), .oRGB(oRGB2), .HBLK(HBLK2), .VBLK(VBLK2),
    .HSYN(HSYN2), .VSYN(VSYN2), .LSTART(LSTART2), .FSTART(FSTART2)
  );

  // c in [b, e) with wrap when e <= b
  function automatic bit in_win(int c, int b, int e);
    if (b < e) return (c >= b) && (c < e);
    return (c >= b) || (c < e);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
    if (PCLK_EN && !RESET) n++;
  endtask

  task automatic test_reset();
    RESET = 1'b1; PCLK_EN = 1'b1; NARROW = 1'b0;
    HOFFS = 4'd0; VOFFS = 4'd0; iRGB = 12'hFFF;
    repeat (3) begin
      tick();
      tests++;
      if ({HBLK, VBLK, HSYN, VSYN, LSTART, FSTART} !== 6'b111100 || oRGB !== 12'h000) begin
        fails++;
        $display("FAIL reset_outs: got blk/syn/strb=%b rgb=%h, want 111100 rgb=000",
                 {HBLK, VBLK, HSYN, VSYN, LSTART, FSTART}, oRGB);
      end
      tests++;
      if (HPOS !== 9'h1F0 || VPOS !== 9'h000) begin
        fails++;
        $display("FAIL reset_pos: got HPOS=%h VPOS=%h, want 1f0 000", HPOS, VPOS);
      end
      tests++;
      if ({HBLK2, VBLK2, HSYN2, VSYN2, LSTART2, FSTART2} !== 6'b111100 ||
          oRGB2 !== 12'h000 || HPOS2 !== 9'h000 || VPOS2 !== 9'h000) begin
        fails++;
        $display("FAIL reset_dutv: got %b rgb=%h hpos=%h vpos=%h, want 111100 000 000 000",
                 {HBLK2, VBLK2, HSYN2, VSYN2, LSTART2, FSTART2}, oRGB2, HPOS2, VPOS2);
      end
    end
    RESET = 1'b0;
    n = 0;
  endtask

  // Frame 0, zero offsets: counting, positions, default syncs, wide gating.
  task automatic test_default();
    int p, ph, pv, p2v, h, v, v2, lcnt, fcnt;
    bit hb, vb;
    logic [CW-1:0] rgb, exp_rgb;
    lcnt = 0; fcnt = 0;
    for (int k = 0; k < F1; k++) begin
      p = n; ph = p % H1; pv = (p / H1) % V1; p2v = (p / H2) % V2;
      rgb = 12'hA5C ^ 12'(p);
      iRGB = rgb;
      tick();
      h = n % H1; v = (n / H1) % V1; v2 = (n / H2) % V2;
      hb = (ph < 29) || (ph >= 285);
      vb = (pv >= 10);
      exp_rgb = (hb || vb) ? 12'h000 : rgb;
      tests++;
      if (HPOS !== 9'(h - 16) || VPOS !== 9'(v)) begin
        fails++;
        $display("FAIL pos n=%0d: got %h/%h, want %h/%h", n, HPOS, VPOS, 9'(h - 16), 9'(v));
      end
      tests++;
      if (HSYN !== !in_win(ph, 296, 320)) begin
        fails++;
        $display("FAIL hsync_default hcnt=%0d: got %b", ph, HSYN);
      end
      tests++;
      if (VSYN !== !in_win(pv, 12, 14)) begin
        fails++;
        $display("FAIL vsync_default vcnt=%0d: got %b", pv, VSYN);
      end
      tests++;
      if ({HBLK, VBLK} !== {hb, vb} || oRGB !== exp_rgb) begin
        fails++;
        $display("FAIL blank_wide h=%0d v=%0d: got %b%b rgb=%h, want %b%b rgb=%h",
                 ph, pv, HBLK, VBLK, oRGB, hb, vb, exp_rgb);
      end
      tests++;
      if (LSTART !== (ph == 0) || FSTART !== (ph == 0 && pv == 0)) begin
        fails++;
        $display("FAIL strobes h=%0d v=%0d: got L=%b F=%b", ph, pv, LSTART, FSTART);
      end
      tests++;
      if (VPOS2 !== 9'(v2 < 256 ? v2 : v2 - 260)) begin
        fails++;
        $display("FAIL vpos_wrap vcnt=%0d: got %h", v2, VPOS2);
      end
      tests++;
      if (VSYN2 !== !in_win(p2v, 234, 238)) begin
        fails++;
        $display("FAIL vsync_lines vcnt=%0d: got %b", p2v, VSYN2);
      end
      lcnt += int'(LSTART);
      fcnt += int'(FSTART);
    end
    tests++;
    if (lcnt != V1 || fcnt != 1) begin
      fails++;
      $display("FAIL strobe_count: got L=%0d F=%0d, want %0d 1", lcnt, fcnt, V1);
    end
  endtask

  // Frame 1: HOFFS 0 -> +4 at line 8 must not move HSYN in this frame.
  // Frame 2: window starts at 300 (wraps to 3); input changed to +7 is ignored.
  task automatic test_offset_latch();
    int p, ph, pv;
    bit frame1;
    for (int k = 0; k < 2 * F1; k++) begin
      p = n; ph = p % H1; pv = (p / H1) % V1;
      frame1 = (p < 2 * F1);
      if (frame1) HOFFS = (pv >= 8) ? 4'd4 : 4'd0;
      else        HOFFS = 4'd7;
      tick();
      tests++;
      if (HSYN !== (frame1 ? !in_win(ph, 296, 320) : !in_win(ph, 300, 4))) begin
        fails++;
        $display("FAIL offset_latch frame=%0d hcnt=%0d: got %b", p / F1, ph, HSYN);
      end
    end
  endtask

  // Frame 3: +7 latched -> B=303, E=7, wraps across the line end.
  task automatic test_wrap_hsync();
    int p, ph;
    HOFFS = 4'b1000; VOFFS = 4'b1000;
    for (int k = 0; k < F1; k++) begin
      p = n; ph = p % H1;
      tick();
      tests++;
      if (HSYN !== !in_win(ph, 303, 7)) begin
        fails++;
        $display("FAIL hsync_wrap hcnt=%0d: got %b", ph, HSYN);
      end
    end
  endtask

  // Frame 4: -8 latched for both axes.
  task automatic test_negative();
    int p, ph, pv, p2v;
    for (int k = 0; k < F1; k++) begin
      p = n; ph = p % H1; pv = (p / H1) % V1; p2v = (p / H2) % V2;
      tick();
      tests++;
      if (HSYN !== !in_win(ph, 288, 312) || VSYN !== !in_win(pv, 4, 6)) begin
        fails++;
        $display("FAIL neg_offs h=%0d v=%0d: got HSYN=%b VSYN=%b", ph, pv, HSYN, VSYN);
      end
      // u_dutv picked up -8 at its frame end p=16639; full frame 20800..22879
      if (p >= 20800 && p < 22880) begin
        tests++;
        if (VSYN2 !== !in_win(p2v, 226, 230)) begin
          fails++;
          $display("FAIL neg_vsync_lines vcnt=%0d: got %b", p2v, VSYN2);
        end
      end
    end
  endtask

  // Frame 5: NARROW toggles every line; gating follows it, HBLK stays wide.
  task automatic test_narrow();
    int p, ph, pv;
    bit nar, hb, gate;
    iRGB = 12'hFFF;
    for (int k = 0; k < F1; k++) begin
      p = n; ph = p % H1; pv = (p / H1) % V1;
      nar = pv[0];
      NARROW = nar;
      tick();
      hb = (ph < 29) || (ph >= 285);
      gate = (nar ? (ph < 37 || ph >= 277) : hb) || (pv >= 10);
      tests++;
      if (HBLK !== hb || oRGB !== (gate ? 12'h000 : 12'hFFF)) begin
        fails++;
        $display("FAIL narrow_gate nar=%b h=%0d v=%0d: got HBLK=%b rgb=%h, want %b %h",
                 nar, ph, pv, HBLK, oRGB, hb, gate ? 12'h000 : 12'hFFF);
      end
    end
    NARROW = 1'b0;
  endtask

  // Hold PCLK_EN low at hcnt=101, line 0 of frame 6; everything must freeze.
  task automatic test_freeze();
    iRGB = 12'hFFF; NARROW = 1'b0;
    repeat (101) tick();
    PCLK_EN = 1'b0; iRGB = 12'h123; NARROW = 1'b1;
    repeat (5) begin
      tick();
      tests++;
      if (HPOS !== 9'h055 || VPOS !== 9'h000 || oRGB !== 12'hFFF ||
          {HBLK, VBLK, HSYN, VSYN, LSTART, FSTART} !== 6'b001100) begin
        fails++;
        $display("FAIL freeze: got hpos=%h vpos=%h rgb=%h flags=%b, want 055 000 fff 001100",
                 HPOS, VPOS, oRGB, {HBLK, VBLK, HSYN, VSYN, LSTART, FSTART});
      end
    end
    PCLK_EN = 1'b1; NARROW = 1'b0;
    tick();
    tests++;
    if (HPOS !== 9'h056 || oRGB !== 12'h123 || HBLK !== 1'b0) begin
      fails++;
      $display("FAIL resume: got hpos=%h rgb=%h hblk=%b, want 056 123 0", HPOS, oRGB, HBLK);
    end
  endtask

  // Reset wins with PCLK_EN low, then the first enable gives both strobes.
  task automatic test_sync_reset();
    PCLK_EN = 1'b0; RESET = 1'b1;
    tick();
    tests++;
    if (HPOS !== 9'h1F0 || VPOS !== 9'h000 || oRGB !== 12'h000 ||
        {HBLK, VBLK, HSYN, VSYN, LSTART, FSTART} !== 6'b111100) begin
      fails++;
      $display("FAIL midrun_reset: got hpos=%h vpos=%h rgb=%h flags=%b", HPOS, VPOS, oRGB,
               {HBLK, VBLK, HSYN, VSYN, LSTART, FSTART});
    end
    RESET = 1'b0; PCLK_EN = 1'b1;
    n = 0;
    tick();
    tests++;
    if (HPOS !== 9'h1F1 || LSTART !== 1'b1 || FSTART !== 1'b1) begin
      fails++;
      $display("FAIL first_strobe: got hpos=%h L=%b F=%b, want 1f1 1 1", HPOS, LSTART, FSTART);
    end
  endtask

  initial begin
    tests = 0; fails = 0; n = 0;
    test_reset();
    test_default();
    test_offset_latch();
    test_wrap_hsync();
    test_negative();
    test_narrow();
    test_freeze();
    test_sync_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the arcade video path.
- Drives H/V pixel coordinates to the tile/sprite renderers.
- Blanks and registers the incoming RGB, and emits blanking and sync to the scaler/analog output.
- Adds to the fixed 320x260 generator:
  - a synchronous reset;
  - parameter-defined raster geometry;
  - a frame-boundary latch for the sync offset inputs;
  - line-start and frame-start strobes.

Parameters:
HTOTAL, 320, pixel clocks per line (max 511)
VTOTAL, 260, lines per frame (max 511)
HACT_BEG, 29, first unblanked hcnt in wide mode
HACT_END, 285, first blanked hcnt after the active region in wide mode
HNARROW, 8, pixels added to HACT_BEG and removed from HACT_END in narrow mode
VACT, 224, active lines; VBLK asserted for vcnt >= VACT
HS_POS, 296, nominal HSYNC start (hcnt)
HS_LEN, 24, HSYNC length in pixel clocks
VS_POS, 234, nominal VSYNC start (vcnt)
VS_LEN, 4, VSYNC length in lines
HBIAS, 16, subtracted from hcnt to form HPOS
CW, 12, RGB width

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
PCLK_EN  in  1  pixel-clock enable; all state advances only when high
NARROW  in  1  1 = narrow (240-pixel) blanking window
HOFFS  in  4  signed HSYNC offset, -8..+7
VOFFS  in  4  signed VSYNC offset, -8..+7
iRGB  in  CW  pixel colour from the mixer
HPOS  out  9  hcnt - HBIAS, modulo 512 (combinational from the counter)
VPOS  out  9  vcnt if vcnt < 256, else vcnt - VTOTAL, modulo 512
oRGB  out  CW  registered, blanked colour
HBLK  out  1  wide-mode horizontal blank, registered
VBLK  out  1  vertical blank, registered
HSYN  out  1  active-low HSYNC, registered
VSYN  out  1  active-low VSYNC, registered
LSTART  out  1  one-enable pulse at hcnt==0
FSTART  out  1  one-enable pulse at hcnt==0 && vcnt==0

Behaviour:
- Reset (CLK edge with RESET=1; has priority over PCLK_EN):
  - hcnt=0, vcnt=0, latched offsets=0.
  - HBLK=1, VBLK=1, HSYN=1, VSYN=1, oRGB=0, LSTART=0, FSTART=0.
- Counters: on PCLK_EN, hcnt increments. At HTOTAL-1, hcnt wraps to 0 and vcnt increments. vcnt wraps to 0 after VTOTAL-1.
- Registered outputs:
  - Each is updated on PCLK_EN from the pre-increment counter values, so there is one enable of latency versus HPOS/VPOS.
  - Between enables, every register holds its value.
- Horizontal blanking:
  - HBLK = (hcnt < HACT_BEG) | (hcnt >= HACT_END).
  - Internal narrow blank uses HACT_BEG+HNARROW and HACT_END-HNARROW.
  - The colour-gating blank selects the narrow or wide window by NARROW; the HBLK port always reports the wide window.
- Vertical blanking: VBLK = vcnt >= VACT.
- oRGB = 0 when (selected hblank | vblank), evaluated from the same counter values; otherwise oRGB = iRGB.
- Offset latch:
  - HOFFS/VOFFS are sampled into internal registers only on the enable where hcnt==HTOTAL-1 and vcnt==VTOTAL-1.
  - Mid-frame changes have no effect until the next frame.
- Sync window arithmetic:
  - B = (POS + sign-extended offset) mod TOTAL. A negative sum adds TOTAL; a sum >= TOTAL subtracts TOTAL.
  - E = (B + LEN) mod TOTAL.
  - Sync is asserted (low) iff cnt lies in [B, E). When E < B the window wraps: asserted for cnt >= B or cnt < E.
  - LEN == 0 means sync is never asserted.
- LSTART/FSTART are registered with the same latency as HSYN, so each is high for exactly one enable period.
- NARROW is not latched and takes effect on the next enable.

Decomposition:
- Shared package video_timing_pkg holds:
  - default geometry constants (320/260/29/285/224/296/24/234/4/16);
  - counter width localparam CNT_W=9;
  - function mod_add(base, signed offs, total) returning the wrapped sum.
- One sub-module, sync_window:
  - Parameters: TOTAL, POS, LEN.
  - Inputs: cnt, offs.
  - Output: active-high in_window, combinational.
  - Instantiated twice (H and V); the top registers and inverts its output.

Test Plan:
- Reset and counting:
  - Stimulus: RESET high 3 cycles with PCLK_EN=1, then release.
  - Required: all outputs at reset values during reset; hcnt runs 0..319; HPOS at hcnt=0 is 9'h1F0.
  - Required: a full frame is 83200 enables; FSTART pulses exactly once per frame; LSTART pulses 260 times per frame.
- Default syncs:
  - Stimulus: HOFFS=0, VOFFS=0.
  - Required: HSYN low for the 24 enables following hcnt=296..319.
  - Required: VSYN low on lines 234..237 (delayed one enable).
  - Required: VPOS for vcnt=259 is 9'h1FF.
- Wrapped HSYNC:
  - Stimulus: HOFFS=+7.
  - Required: B=303, E=7; HSYN low for hcnt 303..319 and 0..6 (24 enables across the line wrap).
- Negative offset:
  - Stimulus: HOFFS=-8, VOFFS=-8.
  - Required: HSYN window 288..311; VSYN on lines 226..229.
- Offset latch timing:
  - Stimulus: change HOFFS 0 -> +4 at vcnt=100.
  - Required: HSYN stays at 296 for the rest of that frame; it moves to 300 starting from the next frame's line 0.
- Blanking and gating:
  - Stimulus: iRGB=12'hFFF; toggle NARROW.
  - Required, wide: oRGB nonzero only for hcnt 29..284 and vcnt < 224.
  - Required, narrow: oRGB nonzero only for hcnt 37..276 and vcnt < 224; HBLK unchanged.
  - Stimulus: PCLK_EN held low for 5 cycles. Required: all outputs frozen.
